// File: rtl/sppm_pulse_qualifier.sv
// SPPM detector pulse qualifier: synchronise, glitch-filter, edge-detect, enforce spacing, count per window.
// Define SPPM_GAP_CHECK_EN to enable the minimum-spacing check between accepted pulses.
module sppm_pulse_qualifier #(
    parameter int WINDOW_CYCLES = 400000,
    parameter int FILTER_LEN    = 4,
    parameter int MIN_GAP       = 40
) (
    input  logic        clk400M,
    input  logic        rst,
    input  logic        sppm,
    output logic        pulse_out,
    output logic [16:0] rate_cnt,
    output logic        rate_valid,
    output logic        rate_sat,
    output logic        gap_err
);

    localparam int               WIN_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [3:0]       RUN_LAST = 4'(FILTER_LEN - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [16:0]      ACC_MAX  = 17'h1FFFF;

    logic [1:0]       sync_q, sync_d;
    logic             filt_q, filt_d;
    logic             filt_prev_q, filt_prev_d;
    logic [3:0]       run_q, run_d;
    logic [1:0]       init_q, init_d;
    logic             armed_q, armed_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [16:0]      acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [16:0]      rate_cnt_q, rate_cnt_d;
    logic             rate_sat_q, rate_sat_d;
    logic             rate_valid_q, rate_valid_d;
    logic             pulse_out_q, pulse_out_d;
    logic             cand;
    logic             accept;
    logic [16:0]      acc_sum;
    logic             acc_sat;

    // Edges are ignored until the filter has been seen low on real synchronised data,
    // so an input held high across reset release never produces a pulse.
    assign cand = filt_q & ~filt_prev_q & armed_q;

`ifdef SPPM_GAP_CHECK_EN
    localparam logic [7:0] GAP_MAX = 8'(MIN_GAP);

    logic [7:0] gap_q, gap_d;
    logic       gap_err_q, gap_err_d;

    always_comb begin
        accept    = cand && (gap_q >= GAP_MAX);
        gap_err_d = cand && !accept;
        gap_d     = gap_q;
        if (accept) begin
            gap_d = 8'd0;
        end else if (gap_q < GAP_MAX) begin
            gap_d = gap_q + 8'd1;
        end
    end

    always_ff @(posedge clk400M) begin
        if (rst) begin
            gap_q     <= GAP_MAX;
            gap_err_q <= 1'b0;
        end else begin
            gap_q     <= gap_d;
            gap_err_q <= gap_err_d;
        end
    end

    assign gap_err = gap_err_q;
`else
    assign accept  = cand;
    assign gap_err = 1'b0;
`endif

    always_comb begin
        sync_d      = {sync_q[0], sppm};
        filt_d      = filt_q;
        run_d       = 4'd0;
        filt_prev_d = filt_q;
        if (sync_q[1] != filt_q) begin
            if (run_q == RUN_LAST) begin
                filt_d = ~filt_q;
            end else begin
                run_d = run_q + 4'd1;
            end
        end
        // init_q reaches 2 once sync_q[1] carries a post-reset sample of sppm
        init_d  = (init_q == 2'd2) ? init_q : init_q + 2'd1;
        armed_d = armed_q | ((init_q == 2'd2) && !filt_q && !sync_q[1]);

        acc_sum = (accept && (acc_q != ACC_MAX)) ? acc_q + 17'd1 : acc_q;
        acc_sat = sat_q | (accept && (acc_q == ACC_MAX));

        win_d        = win_q + WIN_W'(1);
        acc_d        = acc_sum;
        sat_d        = acc_sat;
        rate_cnt_d   = rate_cnt_q;
        rate_sat_d   = rate_sat_q;
        rate_valid_d = 1'b0;
        if (win_q == WIN_LAST) begin
            win_d        = '0;
            acc_d        = 17'd0;
            sat_d        = 1'b0;
            rate_cnt_d   = acc_sum;
            rate_sat_d   = acc_sat;
            rate_valid_d = 1'b1;
        end
        pulse_out_d = accept;
    end

    always_ff @(posedge clk400M) begin
        if (rst) begin
            sync_q       <= 2'b00;
            filt_q       <= 1'b0;
            filt_prev_q  <= 1'b0;
            run_q        <= 4'd0;
            init_q       <= 2'd0;
            armed_q      <= 1'b0;
            win_q        <= '0;
            acc_q        <= 17'd0;
            sat_q        <= 1'b0;
            rate_cnt_q   <= 17'd0;
            rate_sat_q   <= 1'b0;
            rate_valid_q <= 1'b0;
            pulse_out_q  <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            filt_q       <= filt_d;
            filt_prev_q  <= filt_prev_d;
            run_q        <= run_d;
            init_q       <= init_d;
            armed_q      <= armed_d;
            win_q        <= win_d;
            acc_q        <= acc_d;
            sat_q        <= sat_d;
            rate_cnt_q   <= rate_cnt_d;
            rate_sat_q   <= rate_sat_d;
            rate_valid_q <= rate_valid_d;
            pulse_out_q  <= pulse_out_d;
        end
    end

    assign pulse_out  = pulse_out_q;
    assign rate_cnt   = rate_cnt_q;
    assign rate_valid = rate_valid_q;
    assign rate_sat   = rate_sat_q;

endmodule

// File: tb/tb_sppm_pulse_qualifier.sv
// Scoreboard bench for sppm_pulse_qualifier: expected pulse/gap_err cycles and per-window counts
// are recorded as stimulus is driven and checked against DUT strobes on the falling edge.
module tb_sppm_pulse_qualifier;

    localparam int W   = 1000;
    localparam int FL  = 4;
    localparam int MG  = 40;
    localparam int LAT = FL + 3;

    logic        clk400M;
    logic        rst;
    logic        sppm;
    logic        pulse_out;
    logic [16:0] rate_cnt;
    logic        rate_valid;
    logic        rate_sat;
    logic        gap_err;

    sppm_pulse_qualifier #(
        .WINDOW_CYCLES(W),
        .FILTER_LEN   (FL),
        .MIN_GAP      (MG)
    ) dut (
        .clk400M   (clk400M),
        .rst       (rst),
        .sppm      (sppm),
        .pulse_out (pulse_out),
        .rate_cnt  (rate_cnt),
        .rate_valid(rate_valid),
        .rate_sat  (rate_sat),
        .gap_err   (gap_err)
    );

    initial clk400M = 1'b0;
    always #5 clk400M = ~clk400M;

    int cyc = 0;
    always @(posedge clk400M) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int exp_pulse_q[$];
    int exp_gerr_q[$];
    int wcnt[int];
    int rel      = 0;
    int last_acc = -100000;
    int n_pulse  = 0;
    int n_gerr   = 0;
    int n_rv     = 0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk400M);
            #1;
        end
    endtask

    function automatic void model_accept(input int e);
        int k;
        exp_pulse_q.push_back(e);
        last_acc = e;
        k = (e - rel + W - 1) / W;
        if (wcnt.exists(k)) wcnt[k] = wcnt[k] + 1;
        else wcnt[k] = 1;
    endfunction

    // Drive one high period then a low period; called just after a rising edge.
    task automatic drive_pulse(input int hi, input int lo);
        int e;
        e = cyc + LAT;
        if (hi >= FL) begin
`ifdef SPPM_GAP_CHECK_EN
            if (e - last_acc <= MG) exp_gerr_q.push_back(e);
            else model_accept(e);
`else
            model_accept(e);
`endif
        end
        sppm = 1'b1;
        step(hi);
        sppm = 1'b0;
        step(lo);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_pulse_q.size() != 0 || exp_gerr_q.size() != 0) && t < 200) begin
            step(1);
            t++;
        end
        checks++;
        if (exp_pulse_q.size() != 0 || exp_gerr_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending_pulses=%0d pending_gap_err=%0d required=0",
                     exp_pulse_q.size(), exp_gerr_q.size());
        end
    endtask

    task automatic assert_rst(input int n);
        rst = 1'b1;
        step(n);
    endtask

    task automatic release_rst();
        exp_pulse_q.delete();
        exp_gerr_q.delete();
        wcnt.delete();
        last_acc = -100000;
        rst      = 1'b0;
        rel      = cyc;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step(1);
    endtask

    // Scoreboard monitor on the falling edge.
    initial begin
        int  e;
        int  k;
        int  ec;
        bit  exp_rv;
        forever begin
            @(negedge clk400M);
            if (!rst) begin
                if (pulse_out) begin
                    n_pulse++;
                    checks++;
                    if (exp_pulse_q.size() == 0) begin
                        failures++;
                        $display("FAIL pulse_out_unexpected cycle=%0d required=none", cyc);
                    end else begin
                        e = exp_pulse_q.pop_front();
                        if (cyc !== e) begin
                            failures++;
                            $display("FAIL pulse_out_cycle got=%0d required=%0d", cyc, e);
                        end
                    end
                end
                if (gap_err) begin
                    n_gerr++;
                    checks++;
                    if (exp_gerr_q.size() == 0) begin
                        failures++;
                        $display("FAIL gap_err_unexpected cycle=%0d required=none", cyc);
                    end else begin
                        e = exp_gerr_q.pop_front();
                        if (cyc !== e) begin
                            failures++;
                            $display("FAIL gap_err_cycle got=%0d required=%0d", cyc, e);
                        end
                    end
                end
                exp_rv = (cyc > rel) && (((cyc - rel) % W) == 0);
                if (rate_valid || exp_rv) begin
                    checks++;
                    if (rate_valid !== exp_rv) begin
                        failures++;
                        $display("FAIL rate_valid_timing cycle=%0d got=%0b required=%0b",
                                 cyc, rate_valid, exp_rv);
                    end else begin
                        n_rv++;
                        k  = (cyc - rel) / W;
                        ec = wcnt.exists(k) ? wcnt[k] : 0;
                        checks++;
                        if (rate_cnt !== 17'(ec) || rate_sat !== 1'b0) begin
                            failures++;
                            $display("FAIL rate_window cycle=%0d got cnt=%0d sat=%0b required cnt=%0d sat=0",
                                     cyc, rate_cnt, rate_sat, ec);
                        end
                    end
                end
            end
        end
    end

    task automatic test_reset();
        sppm = 1'b0;
        assert_rst(4);
        checks++;
        if (pulse_out !== 1'b0 || gap_err !== 1'b0 || rate_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes got pulse_out=%b gap_err=%b rate_valid=%b required=0 0 0",
                     pulse_out, gap_err, rate_valid);
        end
        checks++;
        if (rate_cnt !== 17'd0 || rate_sat !== 1'b0) begin
            failures++;
            $display("FAIL reset_rate got cnt=%0d sat=%b required=0 0", rate_cnt, rate_sat);
        end
        release_rst();
    endtask

    task automatic test_latency();
        int p0;
        int g0;
        step(10);
        p0 = n_pulse;
        g0 = n_gerr;
        drive_pulse(20, 20);
        wait_drain();
        checks++;
        if (n_pulse - p0 !== 1 || n_gerr - g0 !== 0) begin
            failures++;
            $display("FAIL latency_counts got pulses=%0d gap_errs=%0d required=1 0",
                     n_pulse - p0, n_gerr - g0);
        end
    endtask

    task automatic test_glitch();
        int  p0;
        bit  filt_seen;
        p0        = n_pulse;
        filt_seen = 1'b0;
        sppm      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            filt_seen |= dut.filt_q;
        end
        sppm = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            filt_seen |= dut.filt_q;
        end
        checks++;
        if (filt_seen !== 1'b0 || n_pulse !== p0) begin
            failures++;
            $display("FAIL glitch_reject got filt_seen=%b pulses=%0d required=0 0",
                     filt_seen, n_pulse - p0);
        end
        // exactly FILTER_LEN high cycles is the shortest accepted pulse
        drive_pulse(FL, 20);
        wait_drain();
        checks++;
        if (n_pulse - p0 !== 1) begin
            failures++;
            $display("FAIL glitch_min_len got pulses=%0d required=1", n_pulse - p0);
        end
    endtask

    task automatic test_gap();
        int p0;
        int g0;
        step(60);
        p0 = n_pulse;
        g0 = n_gerr;
        drive_pulse(8, 12);
        drive_pulse(8, 30);
        wait_drain();
        checks++;
`ifdef SPPM_GAP_CHECK_EN
        if (n_pulse - p0 !== 1 || n_gerr - g0 !== 1) begin
            failures++;
            $display("FAIL gap_counts got pulses=%0d gap_errs=%0d required=1 1",
                     n_pulse - p0, n_gerr - g0);
        end
`else
        if (n_pulse - p0 !== 2 || n_gerr - g0 !== 0) begin
            failures++;
            $display("FAIL gap_counts got pulses=%0d gap_errs=%0d required=2 0",
                     n_pulse - p0, n_gerr - g0);
        end
`endif
    endtask

    task automatic test_counting();
        int r0;
        assert_rst(3);
        release_rst();
        step(50);
        for (int i = 0; i < 8; i++) drive_pulse(10, 90);
        wait_drain();
        r0 = n_rv;
        wait_until(rel + W + 2);
        checks++;
        if (rate_cnt !== 17'd8 || rate_sat !== 1'b0 || n_rv - r0 !== 1) begin
            failures++;
            $display("FAIL count_window got cnt=%0d sat=%b strobes=%0d required=8 0 1",
                     rate_cnt, rate_sat, n_rv - r0);
        end
        wait_until(rel + 2 * W + 2);
        checks++;
        if (rate_cnt !== 17'd0 || n_rv - r0 !== 2) begin
            failures++;
            $display("FAIL count_empty_window got cnt=%0d strobes=%0d required=0 2",
                     rate_cnt, n_rv - r0);
        end
    endtask

    task automatic test_boundary();
        assert_rst(3);
        release_rst();
        wait_until(rel + 300);
        drive_pulse(10, 20);
        wait_until(rel + W - LAT);
        drive_pulse(10, 20);
        wait_drain();
        wait_until(rel + W + 30);
        checks++;
        if (rate_cnt !== 17'd2) begin
            failures++;
            $display("FAIL boundary_closing got cnt=%0d required=2", rate_cnt);
        end
        wait_until(rel + 2 * W + 2);
        checks++;
        if (rate_cnt !== 17'd0) begin
            failures++;
            $display("FAIL boundary_next got cnt=%0d required=0", rate_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int r0;
        assert_rst(3);
        release_rst();
        step(30);
        for (int i = 0; i < 5; i++) drive_pulse(10, 50);
        wait_drain();
        wait_until(rel + W + 20);
        checks++;
        if (rate_cnt !== 17'd5) begin
            failures++;
            $display("FAIL reset_mid_pre got cnt=%0d required=5", rate_cnt);
        end
        for (int i = 0; i < 5; i++) drive_pulse(10, 50);
        wait_drain();
        wait_until(rel + W + 450);
        assert_rst(3);
        checks++;
        if (pulse_out !== 1'b0 || gap_err !== 1'b0 || rate_valid !== 1'b0 ||
            rate_cnt !== 17'd0 || rate_sat !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_outputs got %b %b %b %0d %b required=0 0 0 0 0",
                     pulse_out, gap_err, rate_valid, rate_cnt, rate_sat);
        end
        release_rst();
        r0 = n_rv;
        step(20);
        for (int i = 0; i < 3; i++) drive_pulse(10, 50);
        wait_drain();
        wait_until(rel + W - 1);
        checks++;
        if (n_rv - r0 !== 0) begin
            failures++;
            $display("FAIL reset_mid_early got strobes=%0d required=0", n_rv - r0);
        end
        wait_until(rel + W + 2);
        checks++;
        if (n_rv - r0 !== 1 || rate_cnt !== 17'd3) begin
            failures++;
            $display("FAIL reset_mid_post got strobes=%0d cnt=%0d required=1 3",
                     n_rv - r0, rate_cnt);
        end
    endtask

    task automatic test_held_high();
        int p0;
        sppm = 1'b1;
        assert_rst(3);
        release_rst();
        p0 = n_pulse;
        step(40);
        checks++;
        if (n_pulse - p0 !== 0) begin
            failures++;
            $display("FAIL held_high_no_edge got pulses=%0d required=0", n_pulse - p0);
        end
        sppm = 1'b0;
        step(12);
        drive_pulse(10, 20);
        wait_drain();
        checks++;
        if (n_pulse - p0 !== 1) begin
            failures++;
            $display("FAIL held_high_rearm got pulses=%0d required=1", n_pulse - p0);
        end
    endtask

    initial begin
        rst  = 1'b1;
        sppm = 1'b0;
        step(1);
        test_reset();
        test_latency();
        test_glitch();
        test_gap();
        test_counting();
        test_boundary();
        test_reset_mid();
        test_held_high();
        wait_drain();
        step(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout cycle=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
